pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
Parametrised program-counter sequencer that replaces the single-register instruction address generator in the Project 1 datapath. It supports sequential increment, signed relative branch, absolute jump, and register jump. It adds hardware CALL/RETURN through an internal return-address stack (RAS) with depth, full and empty reporting. It feeds instruction memory through PC and supplies the previous-cycle PC on PC_temp for link and return use.

Parameters:
ADDR_W, 32, width of PC, PC_temp, BranchOff, RA and Target.
RAS_DEPTH, 8, number of RAS entries; must be a power of 2 and at least 2.
JUMP_W, 7, width of the debug load address JumpTo.
RESET_VEC, 0, PC value loaded on reset.

Ports:
Clock  in  1  rising-edge clock.
Reset_n  in  1  asynchronous active-low reset.
PC_enable  in  1  advance PC this cycle using PC_select.
PC_select  in  3  operation: 0 NEXT, 1 BRANCH, 2 JUMP_ABS, 3 JUMP_REG, 4 CALL, 5 RETURN, 6 HOLD, 7 NEXT.
BranchOff  in  ADDR_W  signed two's-complement relative offset.
Target  in  ADDR_W  absolute target for JUMP_ABS and CALL.
RA  in  ADDR_W  register-file address for JUMP_REG.
Debug_load  in  1  synchronous debug load of PC (key input).
JumpTo  in  JUMP_W  debug load address (switch input).
Fault_clr  in  1  clears the sticky fault flags.
PC  out  ADDR_W  current instruction address.
PC_temp  out  ADDR_W  PC value from the previous cycle.
Ras_count  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.
Ras_full  out  1  Ras_count equals RAS_DEPTH.
Ras_empty  out  1  Ras_count equals 0.
Ovf_fault  out  1  sticky flag: CALL was issued while the RAS was full.
Unf_fault  out  1  sticky flag: RETURN was issued while the RAS was empty.

Behaviour:
- Reset (Reset_n=0, asynchronous): PC=RESET_VEC, PC_temp=RESET_VEC, Ras_count=0, stack pointer=0, both faults=0. RAS entry contents are don't-care. On deassertion, the first rising edge operates normally.
- PC_temp <= PC on every rising edge, regardless of PC_enable or Debug_load. This gives a one-cycle history.
- Priority, highest first: Reset_n, then Debug_load, then PC_enable.
- Debug_load=1: PC <= zero-extended JumpTo. The RAS is flushed (Ras_count=0). Faults are unchanged. PC_enable is ignored that cycle.
- PC_enable=0 with no Debug_load: PC holds and the RAS is unchanged.
- PC_enable=1, by PC_select; all arithmetic is modulo 2^ADDR_W and wraps silently:
  - NEXT (0 or 7): PC <= PC+1.
  - BRANCH: PC <= PC+BranchOff, with BranchOff treated as signed. The offset is relative to the current PC.
  - JUMP_ABS: PC <= Target.
  - JUMP_REG: PC <= RA.
  - HOLD: PC unchanged. This is distinct from PC_enable=0 only by encoding.
  - CALL: push PC+1 and set PC <= Target.
    - Not full: write at the stack pointer, increment the pointer, Ras_count+1.
    - Full: circular overwrite of the oldest entry. The pointer still advances, Ras_count stays at RAS_DEPTH, and Ovf_fault is set.
  - RETURN:
    - Not empty: PC <= top entry, decrement the pointer, Ras_count-1.
    - Empty: PC <= PC+1, the RAS is unchanged, and Unf_fault is set.
- Faults: set as above and held until Fault_clr=1 or reset. If Fault_clr and a new fault event occur in the same cycle, the fault is set (set wins).
- Latency: every PC change is visible the cycle after the controlling edge. RAS status outputs are registered and update on the same edge as PC.
- Back-to-back CALL then RETURN on consecutive enabled cycles must return the pushed PC+1. This requires an internal bypass if the RAS is built from a registered memory.
- Ras_full and Ras_empty are decoded from Ras_count and are never both 1.

Test Plan:
1. Reset then 4 cycles of PC_enable=1, select=NEXT: PC goes 0,1,2,3,4 and PC_temp lags by one cycle. Assert Reset_n=0 mid-run: PC and PC_temp go to 0 immediately, without waiting for a clock edge.
2. At PC=10, BRANCH with BranchOff=-3 gives PC=7. At PC=2^32-1, NEXT gives PC=0. JUMP_REG with RA=0x40 gives PC=0x40.
3. At PC=5, CALL Target=0x100 gives PC=0x100 and Ras_count=1. Next cycle, RETURN gives PC=6, Ras_count=0 and Ras_empty=1.
4. Issue 9 nested CALLs with RAS_DEPTH=8: Ovf_fault=1 and Ras_count=8. Then 8 RETURNs return addresses 2 through 9 in LIFO order; the first is lost. A 9th RETURN sets Unf_fault=1 and increments PC by 1.
5. Debug_load=1 with JumpTo=7'h55 and PC_enable=1, select=CALL: PC=0x55, Ras_count=0, and no push occurs.
6. Hold Fault_clr=1 while a new underflow occurs: Unf_fault stays 1. Next cycle, Fault_clr=1 alone clears both flags.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with sequential, relative, absolute and
// register jumps, plus hardware CALL/RETURN through a circular return-address stack.

module pc_sequencer_chk #(
  parameter int CNT_W     = 4,
  parameter int RAS_DEPTH = 8
) (
  input logic             Clock,
  input logic             Reset_n,
  input logic [CNT_W-1:0] Ras_count,
  input logic             Ras_full,
  input logic             Ras_empty
);

  // Status flags are mutually exclusive and occupancy never exceeds the stack size.
  a_full_empty: assert property (@(posedge Clock) disable iff (!Reset_n)
    !(Ras_full && Ras_empty));

  a_cnt_range: assert property (@(posedge Clock) disable iff (!Reset_n)
    (32'(Ras_count) <= RAS_DEPTH));

endmodule

module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter int                RAS_DEPTH = 8,
  parameter int                JUMP_W    = 7,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic                         Clock,
  input  logic                         Reset_n,
  input  logic                         PC_enable,
  input  logic [2:0]                   PC_select,
  input  logic [ADDR_W-1:0]            BranchOff,
  input  logic [ADDR_W-1:0]            Target,
  input  logic [ADDR_W-1:0]            RA,
  input  logic                         Debug_load,
  input  logic [JUMP_W-1:0]            JumpTo,
  input  logic                         Fault_clr,
  output logic [ADDR_W-1:0]            PC,
  output logic [ADDR_W-1:0]            PC_temp,
  output logic [$clog2(RAS_DEPTH):0]   Ras_count,
  output logic                         Ras_full,
  output logic                         Ras_empty,
  output logic                         Ovf_fault,
  output logic                         Unf_fault
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  localparam logic [2:0] SEL_NEXT     = 3'd0;
  localparam logic [2:0] SEL_BRANCH   = 3'd1;
  localparam logic [2:0] SEL_JUMP_ABS = 3'd2;
  localparam logic [2:0] SEL_JUMP_REG = 3'd3;
  localparam logic [2:0] SEL_CALL     = 3'd4;
  localparam logic [2:0] SEL_RETURN   = 3'd5;
  localparam logic [2:0] SEL_HOLD     = 3'd6;
  localparam logic [2:0] SEL_NEXT_ALT = 3'd7;

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_temp_r;
  logic [PTR_W-1:0]  sp_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              full_r;
  logic              empty_r;
  logic              ovf_r;
  logic              unf_r;
  logic [ADDR_W-1:0] ras_mem_r [RAS_DEPTH];

  logic [ADDR_W-1:0] pc_nxt_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] load_addr_s;
  logic [ADDR_W-1:0] ras_top_s;
  logic [PTR_W-1:0]  sp_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              push_s;
  logic              ovf_set_s;
  logic              unf_set_s;
  logic              ovf_nxt_s;
  logic              unf_nxt_s;

  // Shared datapath terms: incremented PC, debug load address and stack top.
  always_comb begin
    pc_inc_s                 = pc_r + ADDR_W'(1'b1);
    load_addr_s              = {ADDR_W{1'b0}};
    load_addr_s[JUMP_W-1:0]  = JumpTo;
    ras_top_s                = ras_mem_r[sp_r - PTR_W'(1'b1)];
  end

  // Next PC and stack bookkeeping; sp always points at the next free slot, so
  // when full it points at the oldest entry, which a further CALL overwrites.
  always_comb begin
    pc_nxt_s  = pc_r;
    sp_nxt_s  = sp_r;
    cnt_nxt_s = cnt_r;
    push_s    = 1'b0;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    if (Debug_load) begin
      pc_nxt_s  = load_addr_s;
      sp_nxt_s  = PTR_ZERO;
      cnt_nxt_s = CNT_ZERO;
    end else if (PC_enable) begin
      case (PC_select)
        SEL_NEXT, SEL_NEXT_ALT: pc_nxt_s = pc_inc_s;
        SEL_BRANCH:             pc_nxt_s = pc_r + BranchOff;
        SEL_JUMP_ABS:           pc_nxt_s = Target;
        SEL_JUMP_REG:           pc_nxt_s = RA;
        SEL_HOLD:               pc_nxt_s = pc_r;
        SEL_CALL: begin
          push_s   = 1'b1;
          pc_nxt_s = Target;
          sp_nxt_s = sp_r + PTR_W'(1'b1);
          if (cnt_r == DEPTH_C) begin
            ovf_set_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1'b1);
          end
        end
        SEL_RETURN: begin
          if (cnt_r == CNT_ZERO) begin
            pc_nxt_s  = pc_inc_s;
            unf_set_s = 1'b1;
          end else begin
            pc_nxt_s  = ras_top_s;
            sp_nxt_s  = sp_r - PTR_W'(1'b1);
            cnt_nxt_s = cnt_r - CNT_W'(1'b1);
          end
        end
        default: pc_nxt_s = pc_r;
      endcase
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // Sticky faults: a new event wins over a simultaneous clear.
  always_comb begin
    ovf_nxt_s = ovf_r;
    unf_nxt_s = unf_r;
    if (ovf_set_s) begin
      ovf_nxt_s = 1'b1;
    end else if (Fault_clr) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
    if (unf_set_s) begin
      unf_nxt_s = 1'b1;
    end else if (Fault_clr) begin
      unf_nxt_s = 1'b0;
    end else begin
      unf_nxt_s = unf_r;
    end
  end

  // Architectural state and registered status outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_r      <= RESET_VEC;
      pc_temp_r <= RESET_VEC;
      sp_r      <= PTR_ZERO;
      cnt_r     <= CNT_ZERO;
      full_r    <= 1'b0;
      empty_r   <= 1'b1;
      ovf_r     <= 1'b0;
      unf_r     <= 1'b0;
    end else begin
      pc_r      <= pc_nxt_s;
      pc_temp_r <= pc_r;
      sp_r      <= sp_nxt_s;
      cnt_r     <= cnt_nxt_s;
      full_r    <= (cnt_nxt_s == DEPTH_C);
      empty_r   <= (cnt_nxt_s == CNT_ZERO);
      ovf_r     <= ovf_nxt_s;
      unf_r     <= unf_nxt_s;
    end
  end

  // Stack storage is flop-based, so a RETURN right after a CALL reads the new top directly.
  always_ff @(posedge Clock) begin
    if (push_s) begin
      ras_mem_r[sp_r] <= pc_inc_s;
    end
  end

  assign PC        = pc_r;
  assign PC_temp   = pc_temp_r;
  assign Ras_count = cnt_r;
  assign Ras_full  = full_r;
  assign Ras_empty = empty_r;
  assign Ovf_fault = ovf_r;
  assign Unf_fault = unf_r;

  pc_sequencer_chk #(
    .CNT_W     (CNT_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_chk (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Ras_count (cnt_r),
    .Ras_full  (full_r),
    .Ras_empty (empty_r)
  );

endmodule
